psum_write_arbiter: RTL and testbench

Shares a single Psum buffer write port among NUM_PE processing elements.
Each PE presents wen_buf_Psum and Psum, then stalls until its ready_Psum is asserted. This block grants PEs in round-robin order through a one-entry registered output stage. It counts accepted Psums per PE and flags when every PE has delivered its expected total for the current layer.

---
 rtl/psum_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/psum_write_arbiter.sv | 116 +++++++++++
 tb/tb_psum_write_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/psum_arb_pkg.sv
// Shared types and width helpers for the Psum write arbiter.
// PSUM_TAG_EN widens buf_din to carry the source PE index above the data.
package psum_arb_pkg;

  function automatic int id_width(input int num_pe);
    return (num_pe <= 2) ? 1 : $clog2(num_pe);
  endfunction

`ifdef PSUM_TAG_EN
  localparam bit PSUM_TAG = 1'b1;
`else
  localparam bit PSUM_TAG = 1'b0;
`endif

  function automatic int buf_din_width(input int data_w, input int id_w);
    return PSUM_TAG ? (data_w + id_w) : data_w;
  endfunction

  localparam int DEF_NUM_PE      = 4;
  localparam int DEF_COUNT_WIDTH = 10;

  typedef logic [DEF_COUNT_WIDTH-1:0]     count_t;
  typedef logic [id_width(DEF_NUM_PE)-1:0] id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr wins,
// grant is qualified by en while grant_idx always reports the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  always_comb begin
    logic [IW-1:0] j_idx;
    found     = 1'b0;
    grant_idx = '0;
    j_idx     = '0;
    for (int k = 0; k < N; k++) begin
      j_idx = IW'((int'(ptr) + k) % N);
      if (!found && req[j_idx]) begin
        found     = 1'b1;
        grant_idx = j_idx;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = en & found & (grant_idx == IW'(gi));
  end

endmodule

// File: rtl/psum_write_arbiter.sv
// Shares one Psum buffer write port among NUM_PE PEs with a registered output
// stage, per-PE delivery counters and a layer-complete flag. Option: PSUM_TAG_EN.
module psum_write_arbiter
  import psum_arb_pkg::*;
#(
  parameter int NUM_PE      = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int COUNT_WIDTH = 10,
  parameter int ID_WIDTH    = id_width(NUM_PE)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           Start,
  input  logic [COUNT_WIDTH-1:0]                         psum_total_in,
  input  logic [NUM_PE-1:0]                              pe_wen,
  input  logic [NUM_PE*DATA_WIDTH-1:0]                   pe_psum,
  output logic [NUM_PE-1:0]                              pe_ready,
  input  logic                                           buf_full,
  output logic                                           buf_wen,
  output logic [buf_din_width(DATA_WIDTH, ID_WIDTH)-1:0] buf_din,
  output logic                                           all_done
);

  logic                   out_valid_reg;
  logic [DATA_WIDTH-1:0]  out_data_reg;
  logic [ID_WIDTH-1:0]    rr_ptr_reg;
  logic [ID_WIDTH-1:0]    rr_ptr_next;
  logic [COUNT_WIDTH-1:0] count_reg [NUM_PE];
  logic [COUNT_WIDTH-1:0] psum_total_reg;
  logic                   all_done_reg;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic                   accept_en;
  logic                   accept;
  logic [NUM_PE-1:0]      met;

  // The stage can take a new word when empty or when it drains this cycle.
  assign accept_en = !out_valid_reg || !buf_full;
  assign buf_wen   = out_valid_reg && !buf_full;
  assign accept    = |pe_ready;
  assign all_done  = all_done_reg;

  assign rr_ptr_next = (grant_idx == ID_WIDTH'(NUM_PE - 1)) ? '0
                                                            : grant_idx + ID_WIDTH'(1);

  rr_arbiter #(
    .N  (NUM_PE),
    .IW (ID_WIDTH)
  ) u_rr_arbiter (
    .req       (pe_wen),
    .ptr       (rr_ptr_reg),
    .en        (accept_en),
    .grant     (pe_ready),
    .grant_idx (grant_idx)
  );

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_met
    assign met[gi] = (count_reg[gi] >= psum_total_reg);
  end

`ifdef PSUM_TAG_EN
  logic [ID_WIDTH-1:0] out_id_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_id_reg <= '0;
    end else if (accept) begin
      out_id_reg <= grant_idx;
    end
  end

  assign buf_din = {out_id_reg, out_data_reg};
`else
  assign buf_din = out_data_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      rr_ptr_reg     <= '0;
      psum_total_reg <= '0;
      all_done_reg   <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        count_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= pe_psum[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr_reg    <= rr_ptr_next;
      end else if (buf_wen) begin
        out_valid_reg <= 1'b0;
      end

      if (Start) begin
        psum_total_reg <= psum_total_in;
      end

      // A word accepted alongside Start is the first of the new layer.
      for (int i = 0; i < NUM_PE; i++) begin
        if (Start) begin
          count_reg[i] <= (accept && grant_idx == ID_WIDTH'(i)) ? COUNT_WIDTH'(1) : '0;
        end else if (accept && grant_idx == ID_WIDTH'(i) && count_reg[i] != '1) begin
          count_reg[i] <= count_reg[i] + COUNT_WIDTH'(1);
        end
      end

      if (Start) begin
        all_done_reg <= 1'b0;
      end else if (!out_valid_reg && (&met)) begin
        all_done_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_write_arbiter.sv
// Directed self-checking bench for psum_write_arbiter (default NUM_PE=4, DATA_WIDTH=16).
module tb_psum_write_arbiter;
  import psum_arb_pkg::*;

  localparam int NUM_PE = 4;
  localparam int DW     = 16;
  localparam int CW     = 10;
  localparam int BUF_W  = buf_din_width(DW, id_width(NUM_PE));

  logic               clk = 1'b0;
  logic               rst;
  logic               Start;
  logic [CW-1:0]      psum_total_in;
  logic [NUM_PE-1:0]  pe_wen;
  logic [NUM_PE*DW-1:0] pe_psum;
  logic [NUM_PE-1:0]  pe_ready;
  logic               buf_full;
  logic               buf_wen;
  logic [BUF_W-1:0]   buf_din;
  logic               all_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_write_arbiter #(
    .NUM_PE      (NUM_PE),
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .Start         (Start),
    .psum_total_in (psum_total_in),
    .pe_wen        (pe_wen),
    .pe_psum       (pe_psum),
    .pe_ready      (pe_ready),
    .buf_full      (buf_full),
    .buf_wen       (buf_wen),
    .buf_din       (buf_din),
    .all_done      (all_done)
  );

  function automatic logic [BUF_W-1:0] exp_din(input int id, input logic [DW-1:0] d);
`ifdef PSUM_TAG_EN
    return {id_t'(id), d};
`else
    return BUF_W'(d);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; psum_total_in = '0; pe_wen = '0; pe_psum = '0; buf_full = 1'b0;
    tick();
    tick();
    checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL reset_buf_wen: got %b expected 0", buf_wen); end
    checks++; if (pe_ready !== 4'b0000) begin errors++; $display("FAIL reset_pe_ready: got %b expected 0000", pe_ready); end
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done: got %b expected 0", all_done); end
    checks++; if (buf_din !== '0) begin errors++; $display("FAIL reset_buf_din: got %h expected 0", buf_din); end
    checks++; if (dut.rr_ptr_reg !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr_reg); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    pe_wen = 4'b0010;
    pe_psum = '0;
    pe_psum[1*DW +: DW] = 16'h00AB;
    #1;
    checks++; if (pe_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", pe_ready); end
    tick();
    pe_wen = '0;
    #1;
    checks++; if (buf_wen !== 1'b1) begin errors++; $display("FAIL single_wen: got %b expected 1", buf_wen); end
    checks++; if (buf_din !== exp_din(1, 16'h00AB)) begin errors++; $display("FAIL single_din: got %h expected %h", buf_din, exp_din(1, 16'h00AB)); end
    checks++; if (dut.rr_ptr_reg !== 2'd2) begin errors++; $display("FAIL single_rr_ptr: got %0d expected 2", dut.rr_ptr_reg); end
    tick();
    checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL single_idle_wen: got %b expected 0", buf_wen); end
    checks++; if (buf_din !== exp_din(1, 16'h00AB)) begin errors++; $display("FAIL single_hold_din: got %h expected %h", buf_din, exp_din(1, 16'h00AB)); end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NUM_PE; i++) pe_psum[i*DW +: DW] = DW'(16'h1000 + i);
    pe_wen = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (pe_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, pe_ready, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (buf_wen !== 1'b1 || buf_din !== exp_din((k - 1) % 4, DW'(16'h1000 + (k - 1) % 4)))
          begin errors++; $display("FAIL rr_out%0d: got wen=%b din=%h expected wen=1 din=%h", k, buf_wen, buf_din, exp_din((k - 1) % 4, DW'(16'h1000 + (k - 1) % 4))); end
      end else begin
        checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL rr_first_wen: got %b expected 0", buf_wen); end
      end
      tick();
    end
    pe_wen = '0;
    #1;
    checks++; if (buf_wen !== 1'b1 || buf_din !== exp_din(0, 16'h1000)) begin errors++; $display("FAIL rr_last_out: got wen=%b din=%h expected wen=1 din=%h", buf_wen, buf_din, exp_din(0, 16'h1000)); end
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    // rr_ptr is 1 here: PE1 is accepted first.
    pe_wen = 4'b1111;
    tick();
    buf_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (pe_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0000", k, pe_ready); end
      checks++; if (buf_wen !== 1'b0 || buf_din !== exp_din(1, 16'h1001)) begin errors++; $display("FAIL bp_hold%0d: got wen=%b din=%h expected wen=0 din=%h", k, buf_wen, buf_din, exp_din(1, 16'h1001)); end
      tick();
    end
    buf_full = 1'b0;
    #1;
    checks++; if (buf_wen !== 1'b1 || buf_din !== exp_din(1, 16'h1001)) begin errors++; $display("FAIL bp_drain: got wen=%b din=%h expected wen=1 din=%h", buf_wen, buf_din, exp_din(1, 16'h1001)); end
    checks++; if (pe_ready !== 4'b0100) begin errors++; $display("FAIL bp_accept: got %b expected 0100", pe_ready); end
    tick();
    pe_wen = '0;
    #1;
    checks++; if (buf_wen !== 1'b1 || buf_din !== exp_din(2, 16'h1002)) begin errors++; $display("FAIL bp_next: got wen=%b din=%h expected wen=1 din=%h", buf_wen, buf_din, exp_din(2, 16'h1002)); end
    checks++; if (dut.rr_ptr_reg !== 2'd3) begin errors++; $display("FAIL bp_rr_ptr: got %0d expected 3", dut.rr_ptr_reg); end
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_completion();
    Start = 1'b1; psum_total_in = 10'd2;
    tick();
    Start = 1'b0;
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL done_cleared: got %b expected 0", all_done); end
    pe_wen = 4'b1111;
    for (int k = 0; k < 8; k++) tick();
    pe_wen = '0;
    #1;
    checks++; if (all_done !== 1'b0 || buf_wen !== 1'b1) begin errors++; $display("FAIL done_last_word: got done=%b wen=%b expected done=0 wen=1", all_done, buf_wen); end
    tick();
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL done_early: got %b expected 0", all_done); end
    tick();
    checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_rise: got %b expected 1", all_done); end
    for (int i = 1; i < NUM_PE; i++) begin
      checks++; if (dut.count_reg[i] !== 10'd2) begin errors++; $display("FAIL done_count%0d: got %0d expected 2", i, dut.count_reg[i]); end
    end
    pe_wen = 4'b0001;
    tick();
    pe_wen = '0;
    tick();
    checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b expected 1", all_done); end
    checks++; if (dut.count_reg[0] !== 10'd3) begin errors++; $display("FAIL done_count0: got %0d expected 3", dut.count_reg[0]); end
    $display("test_completion done");
  endtask

  task automatic test_start_traffic();
    // rr_ptr is 1 after the extra PE0 word.
    pe_wen = 4'b0010; pe_psum[1*DW +: DW] = 16'h5A5A;
    Start = 1'b1; psum_total_in = 10'd3;
    #1;
    checks++; if (pe_ready !== 4'b0010) begin errors++; $display("FAIL st_ready: got %b expected 0010", pe_ready); end
    tick();
    Start = 1'b0; pe_wen = '0;
    #1;
    checks++; if (dut.count_reg[1] !== 10'd1) begin errors++; $display("FAIL st_count1: got %0d expected 1", dut.count_reg[1]); end
    checks++; if (dut.count_reg[0] !== 10'd0 || dut.count_reg[2] !== 10'd0 || dut.count_reg[3] !== 10'd0)
      begin errors++; $display("FAIL st_other_counts: got %0d %0d %0d expected 0 0 0", dut.count_reg[0], dut.count_reg[2], dut.count_reg[3]); end
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL st_all_done: got %b expected 0", all_done); end
    checks++; if (buf_wen !== 1'b1 || buf_din !== exp_din(1, 16'h5A5A)) begin errors++; $display("FAIL st_out: got wen=%b din=%h expected wen=1 din=%h", buf_wen, buf_din, exp_din(1, 16'h5A5A)); end
    tick();
    checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL st_no_dup: got %b expected 0", buf_wen); end
    $display("test_start_traffic done");
  endtask

  task automatic test_rst_mid();
    pe_wen = 4'b0100; pe_psum[2*DW +: DW] = 16'hBEEF;
    tick();
    pe_wen = '0; buf_full = 1'b1;
    #1;
    checks++; if (buf_wen !== 1'b0 || buf_din !== exp_din(2, 16'hBEEF)) begin errors++; $display("FAIL rm_held: got wen=%b din=%h expected wen=0 din=%h", buf_wen, buf_din, exp_din(2, 16'hBEEF)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pe_wen = 4'b1000;
    #1;
    checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL rm_wen: got %b expected 0", buf_wen); end
    checks++; if (pe_ready !== 4'b1000) begin errors++; $display("FAIL rm_ready: got %b expected 1000", pe_ready); end
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL rm_all_done: got %b expected 0", all_done); end
    checks++; if (dut.rr_ptr_reg !== 2'd0 || buf_din !== '0) begin errors++; $display("FAIL rm_state: got rr_ptr=%0d din=%h expected 0 0", dut.rr_ptr_reg, buf_din); end
    pe_wen = '0;
    buf_full = 1'b0;
    #1;
    checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL rm_discard: got %b expected 0", buf_wen); end
    tick();
    $display("test_rst_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_completion();
    test_start_traffic();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
